// File: rtl/axi_ram.sv
// axi_ram: AXI4 slave memory, INCR-only, single outstanding write and read.
// Independent write and read FSMs share a dual-port word array; addresses wrap
// modulo the memory size. Memory contents are not reset.
module axi_ram #(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // write address
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic [ID_WIDTH-1:0]     s_awid,
  // write data
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [8*DATA_BYTES-1:0] s_wdata,
  input  logic [DATA_BYTES-1:0]   s_wstrb,
  input  logic                    s_wlast,
  // write response
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  // read address
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic [ID_WIDTH-1:0]     s_arid,
  // read data
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [8*DATA_BYTES-1:0] s_rdata,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast
);

  localparam int unsigned OFF_W = $clog2(DATA_BYTES);
  localparam int unsigned IDX_W = ADDR_WIDTH - OFF_W;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned DW    = 8 * DATA_BYTES;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DW-1:0] mem [DEPTH];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                alive;
  logic [IDX_W-1:0]    wr_idx, rd_idx, rd_idx_nxt;
  logic [7:0]          wr_len, wr_beat, rd_len, rd_beat;
  logic [ID_WIDTH-1:0] wr_id, rd_id;
  logic                wr_err;
  logic [DW-1:0]       rd_data;
  logic                aw_hs, w_hs, ar_hs, r_hs, w_final, r_final;

  // size/burst and sub-word address bits carry no meaning for this slave
  logic unused_fields;
  assign unused_fields = ^{s_awsize, s_awburst, s_arsize, s_arburst,
                           s_awaddr[OFF_W-1:0], s_araddr[OFF_W-1:0]};

  assign aw_hs      = s_awvalid & s_awready;
  assign w_hs       = s_wvalid & s_wready;
  assign ar_hs      = s_arvalid & s_arready;
  assign r_hs       = s_rvalid & s_rready;
  assign w_final    = (wr_beat == wr_len);
  assign r_final    = (rd_beat == rd_len);
  assign rd_idx_nxt = rd_idx + IDX_W'(1);

  // Holds the address-ready outputs low until the first edge after reset release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) alive <= 1'b0;
    else          alive <= 1'b1;
  end

  // ---------------- write channel ----------------

  // Write FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write FSM next state: burst ends by beat count, never by wlast
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)            w_next = W_DATA;
      W_DATA:  if (w_hs && w_final)  w_next = W_RESP;
      W_RESP:  if (s_bready)         w_next = W_IDLE;
      default:                       w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs
  always_comb begin
    s_awready = alive && (w_state == W_IDLE);
    s_wready  = (w_state == W_DATA);
    s_bvalid  = (w_state == W_RESP);
    s_bid     = s_bvalid ? wr_id : '0;
    s_bresp   = (s_bvalid && wr_err) ? 2'b10 : 2'b00;
  end

  // Write burst bookkeeping; a misplaced or missing wlast flags SLVERR
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_idx  <= '0;
      wr_len  <= '0;
      wr_beat <= '0;
      wr_id   <= '0;
      wr_err  <= 1'b0;
    end else if (aw_hs) begin
      wr_idx  <= s_awaddr[ADDR_WIDTH-1:OFF_W];
      wr_len  <= s_awlen;
      wr_beat <= '0;
      wr_id   <= s_awid;
      wr_err  <= 1'b0;
    end else if (w_hs) begin
      wr_idx  <= wr_idx + IDX_W'(1);
      wr_beat <= wr_beat + 8'd1;
      if (s_wlast != w_final) wr_err <= 1'b1;
    end
  end

  // Byte-enabled memory write port (array deliberately not reset)
  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int unsigned b = 0; b < DATA_BYTES; b++) begin
        if (s_wstrb[b]) mem[wr_idx][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------

  // Read FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read FSM next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)            r_next = R_DATA;
      R_DATA:  if (r_hs && r_final)  r_next = R_IDLE;
      default:                       r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    s_arready = alive && (r_state == R_IDLE);
    s_rvalid  = (r_state == R_DATA);
    s_rdata   = rd_data;
    s_rid     = s_rvalid ? rd_id : '0;
    s_rresp   = 2'b00;
    s_rlast   = s_rvalid && r_final;
  end

  // Read data register: prefetches the next word on each accepted non-final
  // beat, so rdata holds while stalled and a same-edge write yields old data
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_data <= '0;
      rd_idx  <= '0;
      rd_len  <= '0;
      rd_beat <= '0;
      rd_id   <= '0;
    end else if (ar_hs) begin
      rd_data <= mem[s_araddr[ADDR_WIDTH-1:OFF_W]];
      rd_idx  <= s_araddr[ADDR_WIDTH-1:OFF_W];
      rd_len  <= s_arlen;
      rd_beat <= '0;
      rd_id   <= s_arid;
    end else if (r_hs && !r_final) begin
      rd_data <= mem[rd_idx_nxt];
      rd_idx  <= rd_idx_nxt;
      rd_beat <= rd_beat + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_ram.sv
// tb_axi_ram: directed stimulus with a queue-based scoreboard for B and R.
module tb_axi_ram;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_awvalid, s_awready;
  logic [11:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic [3:0]  s_awid;
  logic        s_wvalid, s_wready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [11:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [3:0]  s_arid;
  logic        s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [3:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;

  always #5 aclk = ~aclk;

  axi_ram #(.DATA_BYTES(8), .ADDR_WIDTH(12), .ID_WIDTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast)
  );

  typedef struct { logic [63:0] d; logic last; logic [3:0] id; } r_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;

  r_exp_t      r_q[$];
  b_exp_t      b_q[$];
  r_exp_t      r_cur;
  b_exp_t      b_cur;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] wbuf[256];
  logic [63:0] rbuf[256];
  time         aw_t, ar_t;

  logic        stall_prev = 1'b0;
  logic [63:0] stall_d;
  logic        stall_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {16'hBEEF, 16'(i), 16'(~i), 16'(i * 7)};
  endfunction

  // Monitor: compares B and R handshakes against the queued expectations,
  // and checks R outputs hold across a stall
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_bvalid && s_bready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got bid 0x%h, expected no response", s_bid);
        end else begin
          b_cur = b_q.pop_front();
          chk("bid", 64'(s_bid), 64'(b_cur.id));
          chk("bresp", 64'(s_bresp), 64'(b_cur.resp));
        end
      end
      if (stall_prev) begin
        chk("r_hold_valid", 64'(s_rvalid), 64'd1);
        chk("r_hold_data", s_rdata, stall_d);
        chk("r_hold_last", 64'(s_rlast), 64'(stall_last));
      end
      if (s_rvalid && s_rready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got rdata 0x%h, expected no beat", s_rdata);
        end else begin
          r_cur = r_q.pop_front();
          chk("rdata", s_rdata, r_cur.d);
          chk("rlast", 64'(s_rlast), 64'(r_cur.last));
          chk("rid", 64'(s_rid), 64'(r_cur.id));
          chk("rresp", 64'(s_rresp), 64'd0);
        end
      end
      stall_prev = s_rvalid && !s_rready;
      stall_d    = s_rdata;
      stall_last = s_rlast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Called and returns at posedge+1
  task automatic write_burst(input logic [11:0] addr, input int len, input logic [3:0] id,
                             input logic [7:0] strb, input int wlast_at,
                             input logic [1:0] resp, input bit tput);
    int n;
    int stalls;
    b_exp_t e;
    s_awaddr = addr; s_awlen = 8'(len); s_awid = id;
    s_awsize = 3'd3; s_awburst = 2'b01; s_awvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_awready && n < 100) begin @(negedge aclk); n++; end
    if (!s_awready) begin
      chk("awready_timeout", 64'(s_awready), 64'd1);
      s_awvalid = 1'b0;
      return;
    end
    @(posedge aclk); aw_t = $time; #1 s_awvalid = 1'b0;
    e.id = id; e.resp = resp;
    b_q.push_back(e);
    stalls = 0;
    for (int i = 0; i <= len; i++) begin
      s_wvalid = 1'b1; s_wdata = wbuf[i]; s_wstrb = strb; s_wlast = (i == wlast_at);
      @(negedge aclk);
      n = 0;
      while (!s_wready && n < 100) begin @(negedge aclk); n++; stalls++; end
      if (i == 0) chk("wready_after_aw", 64'(n), 64'd0);
      if (!s_wready) begin chk("wready_timeout", 64'(s_wready), 64'd1); break; end
      @(posedge aclk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (tput) chk("w_stall_cycles", 64'(stalls), 64'd0);
    @(negedge aclk); chk("bvalid_latency", 64'(s_bvalid), 64'd1);
    @(posedge aclk); #1;
    @(negedge aclk); chk("awready_after_b", 64'(s_awready), 64'd1);
    @(posedge aclk); #1;
  endtask

  // Called and returns at posedge+1; expected beats come from rbuf
  task automatic read_burst(input logic [11:0] addr, input int len, input logic [3:0] id,
                            input bit toggle);
    int n;
    r_exp_t e;
    for (int i = 0; i <= len; i++) begin
      e.d = rbuf[i]; e.last = (i == len); e.id = id;
      r_q.push_back(e);
    end
    s_araddr = addr; s_arlen = 8'(len); s_arid = id;
    s_arsize = 3'd3; s_arburst = 2'b01; s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_arready && n < 100) begin @(negedge aclk); n++; end
    if (!s_arready) begin
      chk("arready_timeout", 64'(s_arready), 64'd1);
      s_arvalid = 1'b0;
      r_q.delete();
      return;
    end
    @(posedge aclk); ar_t = $time; #1 s_arvalid = 1'b0;
    @(negedge aclk); chk("rvalid_latency", 64'(s_rvalid), 64'd1);
    n = 0;
    while (r_q.size() > 0 && n < 2000) begin
      @(posedge aclk); #1;
      if (toggle) s_rready = ~s_rready;
      n++;
    end
    if (r_q.size() > 0) begin
      chk("r_beats_timeout", 64'(r_q.size()), 64'd0);
      r_q.delete();
    end
    s_rready = 1'b1;
    @(negedge aclk); chk("arready_after_r", 64'(s_arready), 64'd1);
    @(posedge aclk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    r_exp_t e;
    s_awvalid = 0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awid = '0;
    s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_wlast = 0; s_bready = 1;
    s_arvalid = 0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arid = '0;
    s_rready = 1;

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_rdata", s_rdata, 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("rel_awready", 64'(s_awready), 64'd1);
    chk("rel_arready", 64'(s_arready), 64'd1);
    @(posedge aclk); #1;

    // wvalid before AW is not accepted
    s_wvalid = 1'b1;
    @(negedge aclk); chk("wready_in_idle", 64'(s_wready), 64'd0);
    @(posedge aclk); #1 s_wvalid = 1'b0;

    // single beat
    wbuf[0] = 64'h1122334455667788;
    write_burst(12'h010, 0, 4'h3, 8'hFF, 0, 2'b00, 1'b0);
    rbuf[0] = 64'h1122334455667788;
    read_burst(12'h010, 0, 4'h5, 1'b0);

    // partial strobe
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst(12'h010, 0, 4'h6, 8'h0F, 0, 2'b00, 1'b0);
    rbuf[0] = 64'h1122_3344_FFFF_FFFF;
    read_burst(12'h010, 0, 4'h7, 1'b0);

    // wrap-around at the top of memory
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); rbuf[i] = 64'(i + 1); end
    write_burst(12'hFF0, 3, 4'h1, 8'hFF, 3, 2'b00, 1'b0);
    read_burst(12'hFF0, 3, 4'h2, 1'b0);
    rbuf[0] = 64'd3;
    read_burst(12'h000, 0, 4'h2, 1'b0);

    // wlast on beat 2 of 3: SLVERR but data written
    wbuf[0] = 64'hA1; wbuf[1] = 64'hA2; wbuf[2] = 64'hA3;
    write_burst(12'h100, 2, 4'h9, 8'hFF, 1, 2'b10, 1'b0);
    rbuf[0] = 64'hA1; rbuf[1] = 64'hA2; rbuf[2] = 64'hA3;
    read_burst(12'h100, 2, 4'h8, 1'b0);

    // 256-beat burst at full rate, read back with backpressure
    for (int i = 0; i < 256; i++) begin wbuf[i] = pat(i); rbuf[i] = pat(i); end
    write_burst(12'h800, 255, 4'hC, 8'hFF, 255, 2'b00, 1'b1);
    read_burst(12'h800, 255, 4'hD, 1'b1);

    // simultaneous AW and AR; read of word 5 coincides with its write
    wbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA; wbuf[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    write_burst(12'h020, 1, 4'h4, 8'hFF, 1, 2'b00, 1'b0);
    wbuf[0] = 64'hCCCC_CCCC_CCCC_CCCC;
    rbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA; rbuf[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    fork
      write_burst(12'h028, 0, 4'h2, 8'hFF, 0, 2'b00, 1'b0);
      read_burst(12'h020, 1, 4'h3, 1'b0);
    join
    chk("aw_ar_same_edge", 64'(ar_t), 64'(aw_t));
    rbuf[0] = 64'hCCCC_CCCC_CCCC_CCCC;
    read_burst(12'h028, 0, 4'hE, 1'b0);

    // reset in the middle of a read burst
    for (int i = 0; i < 256; i++) begin
      e.d = pat(i); e.last = (i == 255); e.id = 4'hA;
      r_q.push_back(e);
    end
    s_araddr = 12'h800; s_arlen = 8'd255; s_arid = 4'hA; s_arvalid = 1'b1; s_rready = 1'b1;
    @(negedge aclk); chk("mid_arready", 64'(s_arready), 64'd1);
    @(posedge aclk); #1 s_arvalid = 1'b0;
    repeat (8) @(posedge aclk);
    #1 aresetn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("mid_rst_rlast", 64'(s_rlast), 64'd0);
    chk("mid_rst_arready", 64'(s_arready), 64'd0);
    chk("mid_rst_bvalid", 64'(s_bvalid), 64'd0);
    r_q.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("post_rst_arready", 64'(s_arready), 64'd1);
    chk("post_rst_awready", 64'(s_awready), 64'd1);
    chk("post_rst_rvalid", 64'(s_rvalid), 64'd0);
    @(posedge aclk); #1;

    // memory survives reset
    for (int i = 0; i < 4; i++) rbuf[i] = pat(i);
    read_burst(12'h800, 3, 4'hB, 1'b0);

    chk("b_queue_drained", 64'(b_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
